// File: rtl/ramsey_scan_sequencer.sv
// Steps the POP free-precession time through a programmed Ramsey scan, holding each value for N POP cycles.
// Latency: start -> fp_load is 2 clocks; the last counted cycle_done -> next fp_load (or done) is 2 clocks.
// Backpressure: none; cycle_done pulses outside RUN are dropped, and abort wins over everything except reset.
// Ports: clk/reset; start/abort controls; cfg_* scan setup (shadowed at start); cycle_done from POP timer;
//        fp_time/fp_load to POP timer; point_idx, busy, done, cfg_err, sat status.
module ramsey_scan_sequencer #(
   parameter int TIME_W  = 16,
   parameter int POINT_W = 8,
   parameter int CPP_W   = 8
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
   input  logic               abort,
   input  logic [TIME_W-1:0]  cfg_start,
   input  logic [TIME_W-1:0]  cfg_step,
   input  logic [POINT_W-1:0] cfg_points,
   input  logic [CPP_W-1:0]   cfg_cycles_per_point,
   input  logic               cycle_done,
   output logic [TIME_W-1:0]  fp_time,
   output logic               fp_load,
   output logic [POINT_W-1:0] point_idx,
   output logic               busy,
   output logic               done,
   output logic               cfg_err,
   output logic               sat
);

   typedef enum logic [2:0] {S_IDLE, S_LOAD, S_RUN, S_ADVANCE, S_DONE} state_t;

   state_t             state_q, state_d;
   logic [TIME_W-1:0]  fp_time_q, fp_time_d;
   logic               fp_load_q, fp_load_d;
   logic [POINT_W-1:0] point_idx_q, point_idx_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;
   logic               cfg_err_q, cfg_err_d;
   logic               sat_q, sat_d;
   logic [CPP_W-1:0]   cyc_cnt_q, cyc_cnt_d;
   // Shadow copies of the configuration, frozen for the duration of a scan.
   logic [TIME_W-1:0]  sh_start_q, sh_start_d;
   logic [TIME_W-1:0]  sh_step_q, sh_step_d;
   logic [POINT_W-1:0] sh_points_q, sh_points_d;
   logic [CPP_W-1:0]   sh_cpp_q, sh_cpp_d;
   // One extra bit so the carry out of the step addition is visible.
   logic [TIME_W:0]    sum;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= S_IDLE;
         fp_time_q   <= '0;
         fp_load_q   <= 1'b0;
         point_idx_q <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         cfg_err_q   <= 1'b0;
         sat_q       <= 1'b0;
         cyc_cnt_q   <= '0;
         sh_start_q  <= '0;
         sh_step_q   <= '0;
         sh_points_q <= '0;
         sh_cpp_q    <= '0;
      end else begin
         state_q     <= state_d;
         fp_time_q   <= fp_time_d;
         fp_load_q   <= fp_load_d;
         point_idx_q <= point_idx_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         cfg_err_q   <= cfg_err_d;
         sat_q       <= sat_d;
         cyc_cnt_q   <= cyc_cnt_d;
         sh_start_q  <= sh_start_d;
         sh_step_q   <= sh_step_d;
         sh_points_q <= sh_points_d;
         sh_cpp_q    <= sh_cpp_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      fp_time_d   = fp_time_q;
      fp_load_d   = 1'b0;
      point_idx_d = point_idx_q;
      busy_d      = busy_q;
      done_d      = 1'b0;
      cfg_err_d   = cfg_err_q;
      sat_d       = sat_q;
      cyc_cnt_d   = cyc_cnt_q;
      sh_start_d  = sh_start_q;
      sh_step_d   = sh_step_q;
      sh_points_d = sh_points_q;
      sh_cpp_d    = sh_cpp_q;
      sum         = {1'b0, fp_time_q} + {1'b0, sh_step_q};

      if (abort && (state_q != S_IDLE)) begin
         // fp_time and point_idx deliberately hold so software can see where the scan stopped.
         state_d = S_IDLE;
         busy_d  = 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (start && !abort) begin
                  if ((cfg_points == '0) || (cfg_cycles_per_point == '0)) begin
                     state_d   = S_DONE;
                     cfg_err_d = 1'b1;
                  end else begin
                     state_d     = S_LOAD;
                     sh_start_d  = cfg_start;
                     sh_step_d   = cfg_step;
                     sh_points_d = cfg_points;
                     sh_cpp_d    = cfg_cycles_per_point;
                  end
               end
            end
            S_LOAD: begin
               fp_time_d   = sh_start_q;
               fp_load_d   = 1'b1;
               point_idx_d = '0;
               cyc_cnt_d   = '0;
               busy_d      = 1'b1;
               sat_d       = 1'b0;
               cfg_err_d   = 1'b0;
               state_d     = S_RUN;
            end
            S_RUN: begin
               if (cycle_done) begin
                  // Never exceeds cpp, so the counter cannot wrap.
                  cyc_cnt_d = cyc_cnt_q + CPP_W'(1);
                  if (cyc_cnt_q == sh_cpp_q - CPP_W'(1)) begin
                     if (point_idx_q != sh_points_q - POINT_W'(1)) begin
                        state_d = S_ADVANCE;
                     end else begin
                        state_d = S_DONE;
                     end
                  end
               end
            end
            S_ADVANCE: begin
               if (sum[TIME_W]) begin
                  fp_time_d = '1;
                  sat_d     = 1'b1;
               end else begin
                  fp_time_d = sum[TIME_W-1:0];
               end
               fp_load_d   = 1'b1;
               point_idx_d = point_idx_q + POINT_W'(1);
               cyc_cnt_d   = '0;
               state_d     = S_RUN;
            end
            S_DONE: begin
               done_d  = 1'b1;
               busy_d  = 1'b0;
               state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
         endcase
      end
   end

   assign fp_time   = fp_time_q;
   assign fp_load   = fp_load_q;
   assign point_idx = point_idx_q;
   assign busy      = busy_q;
   assign done      = done_q;
   assign cfg_err   = cfg_err_q;
   assign sat       = sat_q;

endmodule

// File: tb/tb_ramsey_scan_sequencer.sv
// Randomized bench for ramsey_scan_sequencer against an event-level scan model.
// Latency: n/a (bench). Backpressure: n/a.
// Inputs are driven 1ns after each rising edge; outputs are sampled at the same point.
module tb_ramsey_scan_sequencer;

   logic        clk = 1'b0;
   logic        reset;
   logic        start, abort, cycle_done;
   logic [15:0] cfg_start, cfg_step;
   logic [7:0]  cfg_points, cfg_cycles_per_point;
   logic [15:0] fp_time;
   logic        fp_load;
   logic [7:0]  point_idx;
   logic        busy, done, cfg_err, sat;

   ramsey_scan_sequencer #(.TIME_W(16), .POINT_W(8), .CPP_W(8)) dut (
      .clk(clk), .reset(reset), .start(start), .abort(abort),
      .cfg_start(cfg_start), .cfg_step(cfg_step), .cfg_points(cfg_points),
      .cfg_cycles_per_point(cfg_cycles_per_point), .cycle_done(cycle_done),
      .fp_time(fp_time), .fp_load(fp_load), .point_idx(point_idx),
      .busy(busy), .done(done), .cfg_err(cfg_err), .sat(sat)
   );

   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;

   // Model of the externally visible values that persist between scans.
   logic [15:0] m_fp;
   int          m_idx;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
      n_vec++;
      if (got !== want) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, want);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic rand_cfg();
      cfg_start            = 16'($urandom);
      cfg_step             = 16'($urandom);
      cfg_points           = 8'($urandom);
      cfg_cycles_per_point = 8'($urandom);
   endtask

   task automatic check_idle(input string tag);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_done"}, done, 0);
      chk({tag, "_load"}, fp_load, 0);
      chk({tag, "_time"}, fp_time, m_fp);
      chk({tag, "_idx"}, point_idx, m_idx);
   endtask

   // mode: 0 run to completion, 1 abort in RUN, 2 abort in LOAD, 3 async reset in RUN.
   // The abort/reset lands after ab_k counted pulses of point ab_pt.
   task automatic run_scan(input logic [15:0] s, input logic [15:0] st, input int pts, input int cpp,
                           input int mode, input int ab_pt, input int ab_k);
      logic [15:0] exp_q[$];
      longint      v;
      bit          exsat;
      int          cnt;
      bit          first;
      bit          pulse;
      exsat = 0;
      for (int i = 0; i < pts; i++) begin
         v = longint'(s) + longint'(i) * longint'(st);
         if (v > 65535) begin
            v = 65535;
            exsat = 1;
         end
         exp_q.push_back(v[15:0]);
      end
      cfg_start = s; cfg_step = st; cfg_points = 8'(pts); cfg_cycles_per_point = 8'(cpp);
      start = 1'b1; abort = 1'b0; cycle_done = 1'b0;
      tick();
      start = 1'b0;
      rand_cfg();
      cycle_done = 1'b1;            // ignored while loading
      chk("load_early", fp_load, 0);
      if (mode == 2) begin
         abort = 1'b1;
         tick();
         abort = 1'b0; cycle_done = 1'b0;
         check_idle("abort_load");
         tick();
         check_idle("abort_load2");
         return;
      end
      tick();
      cycle_done = 1'b0;
      chk("first_load", fp_load, 1);
      chk("first_time", fp_time, exp_q[0]);
      chk("first_idx", point_idx, 0);
      chk("first_busy", busy, 1);
      chk("sat_clr", sat, 0);
      chk("err_clr", cfg_err, 0);
      m_fp = exp_q[0];
      m_idx = 0;
      for (int p = 0; p < pts; p++) begin
         cnt = 0;
         first = 1;
         while (cnt < cpp) begin
            if (!first) begin
               chk("run_load", fp_load, 0);
               chk("run_busy", busy, 1);
               chk("run_done", done, 0);
            end
            first = 0;
            if ((mode == 1 || mode == 3) && p == ab_pt && cnt == ab_k) begin
               if (mode == 1) begin
                  abort = 1'b1;
                  cycle_done = 1'($urandom);
                  tick();
                  abort = 1'b0;
                  check_idle("abort_run");
                  for (int k = 0; k < 3; k++) begin
                     cycle_done = 1'b1;
                     tick();
                     cycle_done = 1'b0;
                     check_idle("abort_ignore");
                  end
               end else begin
                  cycle_done = 1'b0;
                  #3 reset = 1'b1;
                  #1;
                  chk("arst_time", fp_time, 0);
                  chk("arst_idx", point_idx, 0);
                  chk("arst_busy", busy, 0);
                  chk("arst_done", done, 0);
                  chk("arst_load", fp_load, 0);
                  chk("arst_err", cfg_err, 0);
                  chk("arst_sat", sat, 0);
                  #2 reset = 1'b0;
                  m_fp = '0;
                  m_idx = 0;
               end
               return;
            end
            pulse = 1'($urandom);
            cycle_done = pulse;
            start = ($urandom_range(0, 9) == 0);
            rand_cfg();
            if (pulse) cnt++;
            tick();
         end
         // Advance/finish cycle: a pulse here must not count toward the next point.
         chk("adv_load", fp_load, 0);
         chk("adv_done", done, 0);
         if (p < pts - 1) chk("adv_busy", busy, 1);
         cycle_done = 1'($urandom);
         start = 1'($urandom);
         tick();
         cycle_done = 1'b0;
         start = 1'b0;
         if (p < pts - 1) begin
            chk("pt_load", fp_load, 1);
            chk("pt_time", fp_time, exp_q[p+1]);
            chk("pt_idx", point_idx, p + 1);
            chk("pt_busy", busy, 1);
            chk("pt_done", done, 0);
            m_fp = exp_q[p+1];
            m_idx = p + 1;
         end else begin
            chk("end_done", done, 1);
            chk("end_busy", busy, 0);
            chk("end_load", fp_load, 0);
            chk("end_time", fp_time, exp_q[pts-1]);
            chk("end_idx", point_idx, pts - 1);
            chk("end_sat", sat, exsat);
            chk("end_err", cfg_err, 0);
         end
      end
      tick();
      chk("post_done", done, 0);
      chk("post_busy", busy, 0);
   endtask

   task automatic reject(input int pts, input int cpp);
      cfg_start = 16'($urandom); cfg_step = 16'($urandom);
      cfg_points = 8'(pts); cfg_cycles_per_point = 8'(cpp);
      start = 1'b1;
      tick();
      start = 1'b0;
      chk("rej_done0", done, 0);
      chk("rej_busy0", busy, 0);
      chk("rej_load0", fp_load, 0);
      tick();
      chk("rej_done", done, 1);
      chk("rej_err", cfg_err, 1);
      chk("rej_busy", busy, 0);
      chk("rej_load", fp_load, 0);
      chk("rej_time", fp_time, m_fp);
      tick();
      chk("rej_post", done, 0);
      chk("rej_err_hold", cfg_err, 1);
   endtask

   initial begin
      int pts, cpp, md;
      reset = 1'b1; start = 1'b0; abort = 1'b0; cycle_done = 1'b0;
      cfg_start = '0; cfg_step = '0; cfg_points = '0; cfg_cycles_per_point = '0;
      m_fp = '0; m_idx = 0;
      #12 reset = 1'b0;
      chk("rst_time", fp_time, 0);
      chk("rst_idx", point_idx, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_load", fp_load, 0);
      chk("rst_err", cfg_err, 0);
      chk("rst_sat", sat, 0);

      run_scan(16'd100, 16'd50, 3, 2, 0, 0, 0);
      run_scan(16'hFFF0, 16'h0020, 2, 1, 0, 0, 0);
      run_scan(16'd100, 16'd50, 3, 2, 0, 0, 0);
      reject(0, 2);
      run_scan(16'd7, 16'd0, 2, 2, 0, 0, 0);
      reject(3, 0);

      // start together with abort in IDLE is dropped
      cfg_start = 16'd5; cfg_step = 16'd1; cfg_points = 8'd2; cfg_cycles_per_point = 8'd1;
      start = 1'b1; abort = 1'b1;
      tick();
      start = 1'b0; abort = 1'b0;
      check_idle("stab");
      tick();
      check_idle("stab2");

      run_scan(16'd1000, 16'd7, 4, 3, 1, 1, 1);
      run_scan(16'd500, 16'd10, 4, 3, 3, 1, 1);
      run_scan(16'd100, 16'd50, 3, 2, 0, 0, 0);
      run_scan(16'd300, 16'd3, 3, 2, 2, 0, 0);

      for (int r = 0; r < 40; r++) begin
         pts = $urandom_range(1, 6);
         cpp = $urandom_range(1, 4);
         md = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
         run_scan(16'($urandom), ($urandom_range(0, 3) == 0) ? 16'd0 : 16'($urandom_range(0, 20000)),
                  pts, cpp, md, $urandom_range(0, pts - 1), $urandom_range(0, cpp - 1));
         if ($urandom_range(0, 5) == 0) reject(0, $urandom_range(0, 3));
      end

      run_scan(16'd0, 16'd1, 3, 255, 0, 0, 0);
      run_scan(16'd10, 16'd300, 255, 1, 0, 0, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/ramsey_scan_sequencer.md
Name: ramsey_scan_sequencer

Overview:
- Automates free-precession (Ramsey) scans for the POP timing chain, replacing manual button stepping of the free-precession time.
- Steps the free-precession time from a start value by a fixed increment over a programmed number of points.
- Holds each value for a programmed number of complete POP cycles, counted from the cycle_done pulses that the POP timer issues.
- Sits between the mode/button logic and the POP timer. Drives the timer's free-precession setting plus a load strobe.

Parameters:
- TIME_W, 16: width of free-precession time words, in 2.5MHz ticks.
- POINT_W, 8: width of the point count and point index.
- CPP_W, 8: width of the cycles-per-point count.

Ports:
- clk  input  1  2.5MHz system clock; all logic on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  single-cycle request to begin a scan; sampled only in IDLE.
- abort  input  1  single-cycle request to stop the scan; accepted in any state.
- cfg_start  input  TIME_W  first free-precession time.
- cfg_step  input  TIME_W  increment per point, unsigned.
- cfg_points  input  POINT_W  number of scan points.
- cfg_cycles_per_point  input  CPP_W  POP cycles per point.
- cycle_done  input  1  one-clock pulse from the POP timer at the end of each POP cycle.
- fp_time  output  TIME_W  free-precession time presented to the POP timer.
- fp_load  output  1  one-clock strobe; fp_time is valid on that cycle.
- point_idx  output  POINT_W  current point, zero-based.
- busy  output  1  high from LOAD through the last RUN cycle.
- done  output  1  one-clock pulse on normal completion or config rejection.
- cfg_err  output  1  sticky flag; cleared on the next accepted start.
- sat  output  1  sticky flag: fp_time saturated; cleared on the next accepted start.

Behaviour:
- Reset (asynchronous): state=IDLE. fp_time, point_idx, busy, done, fp_load, cfg_err and sat all 0. Internal cycle counter 0.
- States: IDLE, LOAD, RUN, ADVANCE, DONE. All outputs are registered.
- IDLE, start=1, abort=0:
  - If cfg_points==0 or cfg_cycles_per_point==0 → go to DONE with cfg_err=1. No fp_load; busy stays 0.
  - Otherwise → LOAD. Latch all cfg_* inputs into shadow registers; cfg_* changes after this have no effect until the next start.
- LOAD (1 cycle): fp_time←cfg_start, fp_load=1, point_idx←0, cyc_cnt←0, busy=1, sat←0, cfg_err←0 → RUN.
- Latency: start sampled at edge N → fp_load high during cycle N+2 (IDLE→LOAD→RUN registered).
- RUN, counting:
  - Each cycle_done pulse increments cyc_cnt.
  - When cycle_done arrives with cyc_cnt==cpp−1: go to ADVANCE if point_idx<points−1, else DONE.
  - cycle_done during LOAD, ADVANCE, DONE or IDLE is ignored (not counted).
- ADVANCE (1 cycle): fp_time←fp_time+step, fp_load=1, point_idx++, cyc_cnt←0 → RUN.
- Arithmetic: the sum is computed at TIME_W+1 bits. If the carry bit is set, fp_time←all-ones and sat←1, and the scan continues at the saturated value.
- step==0 is legal: the same time is repeated at every point.
- DONE (1 cycle): done=1, busy=0 → IDLE. fp_time and point_idx hold their last values.
- abort in LOAD, RUN, ADVANCE or DONE: next state IDLE, busy=0, fp_load=0, no done pulse. fp_time and point_idx hold.
- abort in IDLE: no effect. start and abort together in IDLE: abort wins and start is ignored.
- start while not in IDLE: ignored.
- Asynchronous reset mid-scan: immediate return to reset values. No done pulse is issued.
- Worst-case length: points × cpp ≤ (2^POINT_W−1)(2^CPP_W−1) POP cycles. Counters must not wrap before that length is reached.

Test Plan:
1. Basic scan: start=100, step=50, points=3, cpp=2 → fp_load pulses with fp_time 100, 150, 200; point_idx 0,1,2. Each advance follows the 2nd cycle_done. done pulses after the 6th cycle_done. busy spans exactly LOAD..last RUN.
2. Saturation: start=16'hFFF0, step=16'h0020, points=2, cpp=1 → 2nd fp_time=16'hFFFF, sat=1, done pulses normally. sat clears on the next accepted start.
3. Config rejection: points=0 (then separately cpp=0) with start → done one cycle after start, cfg_err=1, busy=0, fp_load never asserted.
4. Abort mid-point: points=4, cpp=3; assert abort after the 1st cycle_done of point 1 → IDLE next cycle, no done pulse, fp_time holds the point-1 value, point_idx=1. Further cycle_done pulses are ignored.
5. Edge collisions:
   - start+abort together in IDLE → stays IDLE.
   - start while busy → no effect.
   - cycle_done coincident with ADVANCE → not counted; the next point still needs cpp pulses.
   - cfg_* changed mid-scan → no effect on the running scan.
6. Asynchronous reset asserted between clock edges during RUN → all outputs 0 before the next edge. After deassert, a new start runs scenario 1 correctly.
